// File: rtl/round_pack_pipe_pkg.sv
// Shared definitions for the normalise-round-pack pipeline: rounding modes,
// flag bit positions and the standard IEEE-754 format widths.
package round_pack_pipe_pkg;

  typedef enum logic [2:0] {
    RM_RTZ = 3'b000,
    RM_RUP = 3'b001,
    RM_RDN = 3'b010,
    RM_RNE = 3'b011,
    RM_RNA = 3'b100
  } rnd_mode_e;

  // Bit positions inside the 3-bit flag vectors {overflow, underflow, inexact}
  localparam int unsigned FLAG_INEXACT   = 0;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_W         = 3;

  // (MAN_W, EXP_W) pairs for the supported formats
  localparam int unsigned SP_MAN_W = 23;
  localparam int unsigned SP_EXP_W = 8;
  localparam int unsigned DP_MAN_W = 52;
  localparam int unsigned DP_EXP_W = 11;

  // On overflow, decide between infinity (1) and the largest finite value (0).
  // Undefined mode encodings behave as round-to-nearest-even.
  function automatic logic ovf_to_inf(input logic [2:0] mode, input logic sign);
    logic r;
    case (mode)
      RM_RTZ:  r = 1'b0;
      RM_RUP:  r = !sign;
      RM_RDN:  r = sign;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/round_pack_pipe_inc.sv
// Rounding increment decision: from mode, sign, guard, sticky and the
// mantissa lsb, decide whether the truncated mantissa is bumped by one ulp.
module round_inc_decide
  import round_pack_pipe_pkg::*;
(
  input  logic [2:0] mode_i,
  input  logic       sign_i,
  input  logic       guard_i,
  input  logic       sticky_i,
  input  logic       lsb_i,
  output logic       inc_o
);

  // Per-mode increment rule; encodings 101-111 fall through to RNE
  always_comb begin
    inc_o = 1'b0;
    case (mode_i)
      RM_RTZ:  inc_o = 1'b0;
      RM_RUP:  inc_o = !sign_i && (guard_i || sticky_i);
      RM_RDN:  inc_o = sign_i && (guard_i || sticky_i);
      RM_RNA:  inc_o = guard_i;
      default: inc_o = guard_i && (sticky_i || lsb_i);
    endcase
  end

endmodule

// File: rtl/round_pack_pipe.sv
// Two-stage normalise / round-pack pipeline for the real_mul datapath.
// Stage 1 normalises the raw significand product and extracts mantissa,
// guard and sticky; stage 2 rounds, handles exponent carry, overflow and
// flush-to-zero underflow, and presents the packed fields with per-beat
// flags. valid/ready backpressure with full throughput; sticky status flags.
module round_pack_pipe
  import round_pack_pipe_pkg::*;
#(
  parameter int unsigned MAN_W  = 23,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned PROD_W = 2 * (MAN_W + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_mode,
  input  logic                in_sign,
  input  logic [EXP_W+1:0]    in_exp,
  input  logic [PROD_W-1:0]   in_sig,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sign,
  output logic [EXP_W-1:0]    out_exp,
  output logic [MAN_W-1:0]    out_man,
  output logic                out_inexact,
  output logic                out_overflow,
  output logic                out_underflow,
  input  logic                flags_clr,
  output logic [FLAG_W-1:0]   flags_sticky
);

  // Internal exponent is one bit wider than the input so that the
  // normalise and rounding-carry increments can never wrap.
  localparam int unsigned EXPI_W = EXP_W + 3;
  localparam logic signed [EXPI_W-1:0] EXP_INF = {3'b000, {EXP_W{1'b1}}};

  // ---------------- handshake ----------------
  logic s1_v_q, s2_v_q;
  logic s1_ready, s2_ready;

  assign s2_ready = !s2_v_q || out_ready;
  assign s1_ready = !s1_v_q || s2_ready;
  assign in_ready = s1_ready;

  // ---------------- stage 1: normalise ----------------
  logic                     norm_shift;
  logic [MAN_W-1:0]         s1_man_d,  s1_man_q;
  logic                     s1_g_d,    s1_g_q;
  logic                     s1_s_d,    s1_s_q;
  logic signed [EXPI_W-1:0] s1_exp_d,  s1_exp_q;
  logic                     s1_zero_d, s1_zero_q;
  logic                     s1_tiny_d, s1_tiny_q;
  logic [2:0]               s1_mode_q;
  logic                     s1_sign_q;

  assign norm_shift = in_sig[PROD_W-1];

  // Significand in [2,4) is shifted right by one; the bit shifted out
  // lands in the sticky field, which is the OR of everything below guard.
  always_comb begin
    if (norm_shift) begin
      s1_man_d = in_sig[PROD_W-2 -: MAN_W];
      s1_g_d   = in_sig[PROD_W-2-MAN_W];
      s1_s_d   = |in_sig[PROD_W-3-MAN_W:0];
    end else begin
      s1_man_d = in_sig[PROD_W-3 -: MAN_W];
      s1_g_d   = in_sig[PROD_W-3-MAN_W];
      s1_s_d   = |in_sig[PROD_W-4-MAN_W:0];
    end
    s1_exp_d  = {in_exp[EXP_W+1], in_exp} + {{(EXPI_W-1){1'b0}}, norm_shift};
    s1_zero_d = (in_sig == '0) || (in_sig[PROD_W-1:PROD_W-2] == 2'b00);
    s1_tiny_d = (in_sig != '0) && (in_sig[PROD_W-1:PROD_W-2] == 2'b00);
  end

  // Stage-1 register: capture an accepted input beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_mode_q <= '0;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_man_q  <= '0;
      s1_g_q    <= 1'b0;
      s1_s_q    <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_tiny_q <= 1'b0;
    end else if (s1_ready) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= in_mode;
        s1_sign_q <= in_sign;
        s1_exp_q  <= s1_exp_d;
        s1_man_q  <= s1_man_d;
        s1_g_q    <= s1_g_d;
        s1_s_q    <= s1_s_d;
        s1_zero_q <= s1_zero_d;
        s1_tiny_q <= s1_tiny_d;
      end
    end
  end

  // ---------------- stage 2: round and pack ----------------
  logic                     inc;
  logic                     carry;
  logic [MAN_W-1:0]         man_sum;
  logic signed [EXPI_W-1:0] exp_f;

  round_inc_decide u_inc (
    .mode_i   (s1_mode_q),
    .sign_i   (s1_sign_q),
    .guard_i  (s1_g_q),
    .sticky_i (s1_s_q),
    .lsb_i    (s1_man_q[0]),
    .inc_o    (inc)
  );

  // Mantissa wrap to zero on an all-ones increment carries into the exponent
  always_comb begin
    man_sum = s1_man_q + {{(MAN_W-1){1'b0}}, inc};
    carry   = (&s1_man_q) && inc;
    exp_f   = s1_exp_q + {{(EXPI_W-1){1'b0}}, carry};
  end

  logic                 s2_sign_d, s2_sign_q;
  logic [EXP_W-1:0]     s2_exp_d,  s2_exp_q;
  logic [MAN_W-1:0]     s2_man_d,  s2_man_q;
  logic [FLAG_W-1:0]    s2_flg_d,  s2_flg_q;

  // Final result selection: zero input, flush-to-zero, overflow, normal
  always_comb begin
    s2_sign_d = s1_sign_q;
    s2_exp_d  = '0;
    s2_man_d  = '0;
    s2_flg_d  = '0;
    if (s1_zero_q) begin
      s2_flg_d[FLAG_UNDERFLOW] = s1_tiny_q;
      s2_flg_d[FLAG_INEXACT]   = s1_tiny_q;
    end else if (exp_f[EXPI_W-1] || (exp_f == '0)) begin
      s2_flg_d[FLAG_UNDERFLOW] = 1'b1;
      s2_flg_d[FLAG_INEXACT]   = 1'b1;
    end else if (exp_f >= EXP_INF) begin
      s2_flg_d[FLAG_OVERFLOW] = 1'b1;
      s2_flg_d[FLAG_INEXACT]  = 1'b1;
      if (ovf_to_inf(s1_mode_q, s1_sign_q)) begin
        s2_exp_d = '1;
        s2_man_d = '0;
      end else begin
        s2_exp_d = {{(EXP_W-1){1'b1}}, 1'b0};
        s2_man_d = '1;
      end
    end else begin
      s2_exp_d = exp_f[EXP_W-1:0];
      s2_man_d = man_sum;
      s2_flg_d[FLAG_INEXACT] = s1_g_q || s1_s_q;
    end
  end

  // Stage-2 register: output beat, held while downstream stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_man_q  <= '0;
      s2_flg_q  <= '0;
    end else if (s2_ready) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_sign_q <= s2_sign_d;
        s2_exp_q  <= s2_exp_d;
        s2_man_q  <= s2_man_d;
        s2_flg_q  <= s2_flg_d;
      end
    end
  end

  // ---------------- sticky flags ----------------
  logic [FLAG_W-1:0] sticky_q;

  // Accumulate flags of accepted beats; a same-cycle clear loses to the beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else if (s2_v_q && out_ready) begin
      sticky_q <= (flags_clr ? '0 : sticky_q) | s2_flg_q;
    end else if (flags_clr) begin
      sticky_q <= '0;
    end
  end

  assign out_valid     = s2_v_q;
  assign out_sign      = s2_sign_q;
  assign out_exp       = s2_exp_q;
  assign out_man       = s2_man_q;
  assign out_inexact   = s2_flg_q[FLAG_INEXACT];
  assign out_overflow  = s2_flg_q[FLAG_OVERFLOW];
  assign out_underflow = s2_flg_q[FLAG_UNDERFLOW];
  assign flags_sticky  = sticky_q;

endmodule

// File: tb/tb_round_pack_pipe.sv
// Scoreboard bench for round_pack_pipe (single precision): directed vectors
// with hand-computed packed results; a monitor pops and compares each beat.
module tb_round_pack_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_sig;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_man;
  logic        out_inexact;
  logic        out_overflow;
  logic        out_underflow;
  logic        flags_clr;
  logic [2:0]  flags_sticky;

  round_pack_pipe #(.MAN_W(23), .EXP_W(8), .PROD_W(48)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mode       (in_mode),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_sig        (in_sig),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sign      (out_sign),
    .out_exp       (out_exp),
    .out_man       (out_man),
    .out_inexact   (out_inexact),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .flags_clr     (flags_clr),
    .flags_sticky  (flags_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
    logic        inx;
    logic        ovf;
    logic        uf;
  } beat_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  int    acc_cyc;

  localparam logic [2:0] RTZ = 3'b000, RUP = 3'b001, RDN = 3'b010,
                         RNE = 3'b011, RNA = 3'b100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output beat is compared against the queue head
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got exp=%h man=%h expected no beat", out_exp, out_man);
      end else begin
        beat_t e, a;
        e = sb.pop_front();
        a = '{out_sign, out_exp, out_man, out_inexact, out_overflow, out_underflow};
        check("beat", 64'(a), 64'(e));
      end
    end
  end

  // Present one beat; push its expected result when the handshake is seen
  task automatic send(input logic [2:0] mode, input logic sign, input logic [9:0] e,
                      input logic [47:0] sig, input logic [7:0] xe, input logic [22:0] xm,
                      input logic xi, input logic xo, input logic xu);
    bit ok = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_sign  = sign;
    in_exp   = e;
    in_sig   = sig;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        acc_cyc = cyc;
        sb.push_back('{sign, xe, xm, xi, xo, xu});
        break;
      end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_mode = '0; in_sign = 1'b0;
    in_exp = '0; in_sig = '0; out_ready = 1'b0; flags_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_sticky",    64'(flags_sticky), 64'd0);
    check("rst_data",      64'({out_sign, out_exp, out_man, out_inexact, out_overflow, out_underflow}), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Normalise + latency: accept cycle to first out_valid is two cycles
    send(RNE, 0, 10'd127, 48'h8000_0000_0000, 8'h80, 23'h0, 0, 0, 0);
    begin
      bit seen = 0;
      for (int i = 0; i < 10; i++) begin
        if (out_valid) begin seen = 1; break; end
        @(negedge clk);
      end
      check("latency", 64'(seen ? cyc - acc_cyc : -1), 64'd2);
    end
    drain();

    // Streamed directed vectors
    send(RNE, 0, 10'd127, 48'h4000_0040_0000, 8'h7F, 23'h0,      1, 0, 0); // tie -> even
    send(RNE, 0, 10'd127, 48'h4000_00C0_0000, 8'h7F, 23'h2,      1, 0, 0); // tie -> up
    send(RNE, 0, 10'd127, 48'h7FFF_FFFF_FFFF, 8'h80, 23'h0,      1, 0, 0); // carry
    send(RTZ, 0, 10'd127, 48'h7FFF_FFFF_FFFF, 8'h7F, 23'h7FFFFF, 1, 0, 0);
    send(RTZ, 0, 10'd254, 48'h8000_0000_0000, 8'hFE, 23'h7FFFFF, 1, 1, 0); // overflow
    send(RNE, 0, 10'd254, 48'h8000_0000_0000, 8'hFF, 23'h0,      1, 1, 0);
    send(RNA, 0, 10'd127, 48'h4000_0040_0000, 8'h7F, 23'h1,      1, 0, 0); // tie away
    send(3'b111, 0, 10'd127, 48'h4000_0040_0000, 8'h7F, 23'h0,   1, 0, 0); // acts RNE
    send(RUP, 0, 10'd127, 48'h4000_0000_0001, 8'h7F, 23'h1,      1, 0, 0);
    send(RDN, 0, 10'd127, 48'h4000_0000_0001, 8'h7F, 23'h0,      1, 0, 0);
    send(RDN, 1, 10'd127, 48'h4000_0000_0001, 8'h7F, 23'h1,      1, 0, 0);
    send(RUP, 1, 10'd254, 48'h8000_0000_0000, 8'hFE, 23'h7FFFFF, 1, 1, 0);
    send(RDN, 1, 10'd254, 48'h8000_0000_0000, 8'hFF, 23'h0,      1, 1, 0);
    send(RUP, 0, 10'd254, 48'h8000_0000_0000, 8'hFF, 23'h0,      1, 1, 0);
    send(RNE, 1, 10'd127, 48'h0,              8'h00, 23'h0,      0, 0, 0); // signed zero
    send(RNE, 0, 10'd127, 48'h0000_1000_0000, 8'h00, 23'h0,      1, 0, 1); // tiny sig
    send(RNE, 0, 10'd0,   48'h7FFF_FFFF_FFFF, 8'h01, 23'h0,      1, 0, 0); // carry out of 0
    send(RNE, 0, 10'h3FF, 48'h8000_0000_0000, 8'h00, 23'h0,      1, 0, 1); // exp -1 +1 = 0
    send(RNE, 0, 10'd254, 48'h7FFF_FFFF_FFFF, 8'hFF, 23'h0,      1, 1, 0); // carry to ovf
    send(RNE, 0, 10'd253, 48'h7FFF_FFFF_FFFF, 8'hFE, 23'h0,      1, 0, 0); // max normal exp
    send(RTZ, 0, 10'd127, 48'h8000_0000_0001, 8'h80, 23'h0,      1, 0, 0); // shifted-out sticky
    send(RNE, 0, 10'd127, 48'h8000_0080_0000, 8'h80, 23'h0,      1, 0, 0); // guard after shift
    send(RNA, 0, 10'd127, 48'h8000_0080_0000, 8'h80, 23'h1,      1, 0, 0);
    drain();

    // Backpressure: four back-to-back beats, out_ready low three cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      for (int k = 1; k <= 4; k++)
        send(RNE, 0, 10'd127, 48'h4000_0000_0000 | (48'(k) << 23), 8'h7F, 23'(k), 0, 0, 0);
      begin repeat (3) @(posedge clk); #1 out_ready = 1'b1; end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_held",     64'({out_valid, out_man}), 64'({1'b1, 23'h1}));
      end
    join
    drain();

    // Sticky flags: underflow beat, clear, then clear colliding with a flagged beat
    flags_clr = 1'b1; @(posedge clk); #1 flags_clr = 1'b0;
    send(RNE, 0, 10'd0, 48'h4000_0000_0000, 8'h00, 23'h0, 1, 0, 1);
    drain();
    @(negedge clk);
    check("sticky_uf", 64'(flags_sticky), 64'b011);
    @(posedge clk); #1 flags_clr = 1'b1;
    @(posedge clk); #1 flags_clr = 1'b0;
    @(negedge clk);
    check("sticky_clr", 64'(flags_sticky), 64'b000);
    @(posedge clk); #1 flags_clr = 1'b1;
    send(RNE, 0, 10'd254, 48'h8000_0000_0000, 8'hFF, 23'h0, 1, 1, 0);
    begin
      bit seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (out_valid) begin seen = 1; break; end
      end
      check("clr_beat_seen", 64'(seen), 64'd1);
    end
    @(posedge clk); #1 flags_clr = 1'b0;
    @(negedge clk);
    check("sticky_beat_wins", 64'(flags_sticky), 64'b101);
    drain();

    // Reset mid-stream: in-flight beats are discarded
    out_ready = 1'b0;
    send(RNE, 0, 10'd127, 48'h4000_0000_0000, 8'h7F, 23'h0, 0, 0, 0);
    send(RNE, 0, 10'd128, 48'h4000_0000_0000, 8'h80, 23'h0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    sb.delete();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    begin
      int seen_out = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (out_valid) seen_out++;
      end
      check("no_out_after_rst", 64'(seen_out), 64'd0);
    end
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_sticky",   64'(flags_sticky), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
